// File: rtl/pqr5_bru_pkg.sv
// Shared types and branch-condition encodings for the PQR5 branch resolver.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pqr5_bru_pkg;

    // Conditional-branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Resolved control-transfer kind after opcode priority
    typedef enum logic [1:0] {
        CT_NONE,
        CT_JAL,
        CT_JALR,
        CT_BR
    } ctrl_kind_t;

    // Funct3 codes 010/011 are not real branches: they resolve not-taken and
    // must never raise a flush, even if fetch predicted them taken.
    function automatic logic f3_is_branch(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // Priority decode of the op flags: JAL > JALR > branch
    function automatic ctrl_kind_t decode_kind(input logic is_jal,
                                               input logic is_jalr,
                                               input logic is_branch);
        if (is_jal)
            return CT_JAL;
        else if (is_jalr)
            return CT_JALR;
        else if (is_branch)
            return CT_BR;
        else
            return CT_NONE;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition comparator: evaluates funct3 against two operands.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module branch_cmp
    import pqr5_bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond_true
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // Select the condition; unused encodings resolve not-taken
    always_comb begin
        cond_true = 1'b0;
        unique case (funct3)
            F3_BEQ:  cond_true = eq;
            F3_BNE:  cond_true = !eq;
            F3_BLT:  cond_true = lt_s;
            F3_BGE:  cond_true = !lt_s;
            F3_BLTU: cond_true = lt_u;
            F3_BGEU: cond_true = !lt_u;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: checks the fetch prediction, flushes and redirects on a miss.
// Latency: one cycle from evaluation to o_flush/o_redirect_pc; flush is a single-cycle pulse.
// Backpressure: i_stall blocks evaluation and holds counters; the flush pulse self-clears regardless.
module branch_resolver
    import pqr5_bru_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32,
    parameter int PC_INCR = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_stall,
    input  logic             i_instr_valid,
    input  logic             i_is_op_jal,
    input  logic             i_is_op_jalr,
    input  logic             i_is_op_branch,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_bp_taken,
    input  logic             i_cnt_clr,
    output logic             o_flush,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic             flush_rg;
    logic [XLEN-1:0]  redirect_rg;
    logic [CNT_W-1:0] br_cnt_rg;
    logic [CNT_W-1:0] mispred_cnt_rg;

    ctrl_kind_t       kind;
    logic             cond_true;
    logic             eval;
    logic             act_taken;
    logic             mispred;
    logic [XLEN-1:0]  pc_rel_tgt;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  redirect_nxt;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .funct3    (i_funct3),
        .rs1       (i_rs1),
        .rs2       (i_rs2),
        .cond_true (cond_true)
    );

    assign kind = decode_kind(i_is_op_jal, i_is_op_jalr, i_is_op_branch);

    // The slot right after a flush holds a wrong-path instruction, so it is skipped
    assign eval = i_instr_valid && !i_stall && !flush_rg && (kind != CT_NONE);

    // Address arithmetic wraps modulo 2^XLEN
    assign pc_rel_tgt = i_pc + i_imm;
    assign jalr_sum   = i_rs1 + i_imm;
    assign seq_pc     = i_pc + XLEN'(PC_INCR);

    // Actual outcome, target and mispredict verdict for the current instruction
    always_comb begin
        act_taken = 1'b0;
        mispred   = 1'b0;
        target    = pc_rel_tgt;
        unique case (kind)
            CT_JAL: begin
                act_taken = 1'b1;
                mispred   = !i_bp_taken;
            end
            CT_JALR: begin
                // Fetch never predicts JALR, so it always redirects
                act_taken = 1'b1;
                mispred   = 1'b1;
                target    = {jalr_sum[XLEN-1:1], 1'b0};
            end
            CT_BR: begin
                act_taken = cond_true;
                mispred   = f3_is_branch(i_funct3) && (cond_true != i_bp_taken);
            end
            default: begin
                act_taken = 1'b0;
                mispred   = 1'b0;
            end
        endcase
    end

    assign redirect_nxt = act_taken ? target : seq_pc;

    // Flush pulse: set by a mispredicting evaluation, always cleared the cycle after
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            flush_rg <= 1'b0;
        else
            flush_rg <= eval && mispred;
    end

    // Redirect PC loads only on a mispredict and holds otherwise
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            redirect_rg <= '0;
        else if (eval && mispred)
            redirect_rg <= redirect_nxt;
    end

    // Saturating performance counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            br_cnt_rg      <= '0;
            mispred_cnt_rg <= '0;
        end else if (i_cnt_clr) begin
            br_cnt_rg      <= '0;
            mispred_cnt_rg <= '0;
        end else if (eval) begin
            if (br_cnt_rg != '1)
                br_cnt_rg <= br_cnt_rg + CNT_W'(1);
            if (mispred && (mispred_cnt_rg != '1))
                mispred_cnt_rg <= mispred_cnt_rg + CNT_W'(1);
        end
    end

    assign o_flush       = flush_rg;
    assign o_redirect_pc = redirect_rg;
    assign o_br_cnt      = br_cnt_rg;
    assign o_mispred_cnt = mispred_cnt_rg;

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage branch resolution unit for the PQR5 core. It is the consumer end of the Fetch Unit's static prediction.
- It takes each control-transfer instruction, together with the taken/not-taken prediction carried down the pipe, and evaluates the real outcome from the operands.
- On a wrong prediction it issues a registered one-cycle flush plus a redirect PC back to the Fetch Unit. It also keeps branch/mispredict performance counters.

Parameters:
- XLEN, 32, data/address width; tracks `XLEN.
- CNT_W, 32, width of each performance counter.
- PC_INCR, 4, sequential PC increment used for the fall-through address.

Ports:
- clk  in  1  Clock
- aresetn  in  1  Asynchronous reset, active-low
- i_stall  in  1  EXU stall; holds all state except the flush self-clear
- i_instr_valid  in  1  Instruction at EXU input is valid
- i_is_op_jal  in  1  JAL
- i_is_op_jalr  in  1  JALR
- i_is_op_branch  in  1  Conditional branch
- i_funct3  in  3  Branch condition code
- i_rs1  in  XLEN  Operand 1 (forwarded)
- i_rs2  in  XLEN  Operand 2 (forwarded)
- i_imm  in  XLEN  Sign-extended immediate (J/I/B, per opcode)
- i_pc  in  XLEN  PC of the instruction
- i_bp_taken  in  1  Fetch prediction piped with the instruction
- i_cnt_clr  in  1  Synchronous clear of both counters
- o_flush  out  1  Misprediction flush, one-cycle pulse
- o_redirect_pc  out  XLEN  Correct next PC, valid while o_flush=1
- o_br_cnt  out  CNT_W  Resolved control-transfer count
- o_mispred_cnt  out  CNT_W  Mispredict count

Behaviour:
- **Reset.** On reset, o_flush=0, o_redirect_pc=0, and both counters are 0.
- **Evaluate condition.** An instruction is evaluated when i_instr_valid=1, i_stall=0, flush_rg=0, and at least one op flag is set.
- **Opcode priority.** If several op flags are asserted: JAL > JALR > branch.
- **Actual outcome and target.**
  - JAL: taken; target = i_pc + i_imm.
  - JALR: taken; target = (i_rs1 + i_imm) & ~1.
  - Branch: target = i_pc + i_imm. The condition depends on funct3:
    - 000 BEQ (==), 001 BNE (!=)
    - 100 BLT (signed <), 101 BGE (signed >=)
    - 110 BLTU (unsigned <), 111 BGEU (unsigned >=)
    - 010 and 011 resolve not-taken and never flush.
- **Arithmetic.** All additions are modulo 2^XLEN; wrap-around is not flagged.
- **Mispredict rules.**
  - JALR: always a mispredict, because fetch never predicts JALR.
  - JAL or branch: mispredict iff the actual outcome != i_bp_taken.
  - Redirect PC is the target when actually taken, otherwise i_pc + PC_INCR.
  - A correct taken prediction needs no redirect, since the fetch target is identical to pc+imm.
- **Latency.** One cycle. Evaluation in cycle N gives o_flush=1 and o_redirect_pc in cycle N+1.
- **Flush pulse.**
  - If flush_rg=1, the next cycle has flush_rg=0 unconditionally, including under i_stall.
  - The instruction presented at the input during the flush cycle is wrong-path. It is ignored: not evaluated and not counted.
- **Redirect PC register.**
  - Loads only on a mispredict evaluation.
  - Holds otherwise, including through stall.
- **Stall.** While i_stall=1, no evaluation occurs and the counters hold.
- **Counters.**
  - o_br_cnt increments on every evaluated instruction.
  - o_mispred_cnt increments when that evaluation mispredicts.
  - Both saturate at all-ones.
  - i_cnt_clr has priority over a same-cycle increment: the result is 0.
- **Mid-operation reset.** Asserting aresetn low at any time immediately clears o_flush and the counters. No pending redirect survives reset.

Decomposition:
- **Package pqr5_bru_pkg.**
  - Funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - typedef enum logic [1:0] {CT_NONE, CT_JAL, CT_JALR, CT_BR} ctrl_kind_t.
- **Sub-module branch_cmp.** Combinational; takes funct3, rs1 and rs2 and returns cond_true. It is reusable by a future dynamic predictor checker.

Test Plan:
- BEQ backward taken, correctly predicted: pc=0x100, imm=0xFFFFFFF0, rs1=rs2=5, bp_taken=1 -> o_flush stays 0; br_cnt=1, mispred_cnt=0.
- BNE forward, mispredicted: pc=0x200, imm=0x20, rs1=1, rs2=2, bp_taken=0 -> next cycle o_flush=1 for exactly 1 cycle, redirect=0x220; mispred_cnt=1.
- BLT backward predicted taken, actually not taken (rs1=5, rs2=-3 signed) at pc=0x300 -> flush, redirect=0x304. Repeat with BLTU where rs1=0xFFFFFFFF, rs2=1 -> not taken, same redirect.
- JALR, rs1=0x1001, imm=0x10 -> flush, redirect=0x1010. A valid branch presented in the flush cycle -> ignored: no flush in the following cycle, counters unchanged.
- Stall over a mispredicting BGE: hold i_stall=1 for 3 cycles -> no flush and no count. Release -> flush one cycle later. Also assert flush, then i_stall=1 -> flush drops after 1 cycle anyway.
- Counter saturation with CNT_W=4: 20 mispredicts -> both counters =15. i_cnt_clr together with an evaluation -> both 0. Reset mid-flush -> o_flush=0 immediately.
